// File: rtl/mem_stage_p.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_p
// Purpose  : Pipeline MEM stage. Holds a byte-lane-writable data memory,
//            resolves branches combinationally and registers the MEM/WB
//            pipeline state, including load extraction and sign extension.
// Ports    : clk, rst_n (async, active-low)
//            in_valid, stall, flush          - pipeline control
//            mem_wr, branch, memtoreg, reg_wr, zero, load_ext, dsize, rw
//                                            - decoded instruction fields
//            exec_result, bus_b, branch_target - address/ALU result, store
//                                              data, branch target
//            pc_src, branch_target_out       - combinational branch outcome
//            wb_valid, wb_memtoreg, wb_reg_wr, misalign, wb_rw,
//            wb_exec_result, wb_dmem         - registered MEM/WB outputs
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_p #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic            mem_wr,
    input  logic            branch,
    input  logic            memtoreg,
    input  logic            reg_wr,
    input  logic            zero,
    input  logic            load_ext,
    input  logic [1:0]      dsize,
    input  logic [4:0]      rw,
    input  logic [XLEN-1:0] exec_result,
    input  logic [XLEN-1:0] bus_b,
    input  logic [XLEN-1:0] branch_target,
    output logic            pc_src,
    output logic [XLEN-1:0] branch_target_out,
    output logic            wb_valid,
    output logic            wb_memtoreg,
    output logic            wb_reg_wr,
    output logic            misalign,
    output logic [4:0]      wb_rw,
    output logic [XLEN-1:0] wb_exec_result,
    output logic [XLEN-1:0] wb_dmem
);

    localparam int c_NB   = XLEN / 8;          // byte lanes per word
    localparam int c_OFFW = $clog2(c_NB);      // byte-offset bits
    localparam int c_IDXW = $clog2(DEPTH);     // word-index bits

    logic [XLEN-1:0]   r_mem [DEPTH];

    logic              w_act;
    logic [c_OFFW-1:0] w_off;
    logic [c_IDXW-1:0] w_idx;
    logic [1:0]        w_size;
    logic              w_misaligned;
    logic              w_memMis;
    logic              w_we;
    logic [c_NB-1:0]   w_sizeMask;
    logic [c_NB-1:0]   w_laneMask;
    logic [XLEN-1:0]   w_wrData;
    logic [XLEN-1:0]   w_rdWord;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_keepMask;
    logic              w_signBit;
    logic [XLEN-1:0]   w_loadData;

    logic              r_wbValid;
    logic              r_wbMemtoreg;
    logic              r_wbRegWr;
    logic              r_misalign;
    logic [4:0]        r_wbRw;
    logic [XLEN-1:0]   r_wbExecResult;
    logic [XLEN-1:0]   r_wbDmem;

    assign w_act             = in_valid & ~flush;
    assign pc_src            = w_act & branch & zero;
    assign branch_target_out = branch_target;

    // Upper address bits beyond the memory span are ignored (wrap-around).
    assign w_off = exec_result[c_OFFW-1:0];
    assign w_idx = exec_result[c_OFFW +: c_IDXW];

    // A dword request on a 32-bit datapath degrades to a word access.
    assign w_size = ((XLEN == 32) && (dsize == 2'b11)) ? 2'b10 : dsize;

    always_comb begin
        w_misaligned = 1'b0;
        w_sizeMask   = c_NB'(1);
        w_keepMask   = XLEN'(8'hFF);
        w_signBit    = 1'b0;
        case (w_size)
            2'b00: begin
                w_sizeMask = c_NB'(1);
                w_keepMask = XLEN'(8'hFF);
                w_signBit  = w_shifted[7];
            end
            2'b01: begin
                w_misaligned = exec_result[0];
                w_sizeMask   = c_NB'(2'b11);
                w_keepMask   = XLEN'(16'hFFFF);
                w_signBit    = w_shifted[15];
            end
            2'b10: begin
                w_misaligned = |exec_result[1:0];
                w_sizeMask   = c_NB'(4'hF);
                w_keepMask   = XLEN'(32'hFFFF_FFFF);
                w_signBit    = w_shifted[31];
            end
            default: begin
                w_misaligned = |exec_result[2:0];
                w_sizeMask   = '1;
                w_keepMask   = '1;
                w_signBit    = 1'b0;
            end
        endcase
    end

    // Only a memory access can be misaligned in a meaningful sense; ALU
    // results that happen to look like odd addresses must still retire.
    assign w_memMis = (mem_wr | memtoreg) & w_misaligned;

    // Reset level is sampled here so a store presented while rst_n is low
    // never reaches the array.
    assign w_we       = w_act & mem_wr & ~stall & ~w_misaligned & rst_n;
    assign w_laneMask = w_sizeMask << w_off;
    assign w_wrData   = bus_b << {w_off, 3'b000};

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int b = 0; b < c_NB; b++) begin
                if (w_laneMask[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wrData[b*8 +: 8];
                end
            end
        end
    end

    // The array read feeds the MEM/WB register directly, giving a
    // one-cycle load latency; a store on the previous edge is already
    // visible here.
    assign w_rdWord   = r_mem[w_idx];
    assign w_shifted  = w_rdWord >> {w_off, 3'b000};
    assign w_loadData = (w_shifted & w_keepMask) |
                        ((load_ext & w_signBit) ? ~w_keepMask : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbValid      <= 1'b0;
            r_wbMemtoreg   <= 1'b0;
            r_wbRegWr      <= 1'b0;
            r_misalign     <= 1'b0;
            r_wbRw         <= '0;
            r_wbExecResult <= '0;
            r_wbDmem       <= '0;
        end else if (!stall) begin
            r_wbValid      <= w_act;
            r_wbMemtoreg   <= w_act & memtoreg;
            r_wbRegWr      <= w_act & reg_wr & ~w_memMis;
            r_misalign     <= w_act & w_memMis;
            r_wbRw         <= rw;
            r_wbExecResult <= exec_result;
            r_wbDmem       <= w_loadData;
        end
    end

    assign wb_valid       = r_wbValid;
    assign wb_memtoreg    = r_wbMemtoreg;
    assign wb_reg_wr      = r_wbRegWr;
    assign misalign       = r_misalign;
    assign wb_rw          = r_wbRw;
    assign wb_exec_result = r_wbExecResult;
    assign wb_dmem        = r_wbDmem;

endmodule
`default_nettype wire
